// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer
// Transmit-side HDLC controller. Pulls frame bytes from the Tx buffer and
// serialises them LSB first onto Tx as: opening flag, bit-stuffed data,
// closing flag. A rising edge on Tx_AbortFrame during a frame replaces the
// remainder with an abort sequence (0 followed by seven 1s).
//
// Ports
//   Clk              system clock, posedge
//   Rst              asynchronous reset, active low
//   Tx_Enable        start request, honoured only in IDLE
//   Tx_Len           frame length in bytes, latched on an accepted start
//   Tx_AbortFrame    abort request, rising edge significant
//   Tx_Data          buffer head byte, consumed when Tx_RdBuff=1
//   Tx_RdBuff        combinational one-cycle read strobe
//   Tx               serial line (3-stage registered pipeline, idles 1)
//   Tx_ValidFrame    frame in progress (opening flag and data)
//   Tx_AbortedTrans  sticky: last frame was aborted
//   Tx_Done          one-cycle pulse on normal completion
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | line idles at 1, waiting for an accepted Tx_Enable
// S_START_FLAG | opening flag 01111110, first byte read in last cycle
// S_DATA       | data bits LSB first with zero insertion after five 1s
// S_END_FLAG   | closing flag 01111110, no stuffing
// S_ABORT      | abort sequence 0 then seven 1s

module hdlc_tx_sequencer #(
   parameter int MAX_BYTES = 126,
   parameter int LEN_W     = 8
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Tx_Enable,
   input  logic [LEN_W-1:0] Tx_Len,
   input  logic             Tx_AbortFrame,
   input  logic [7:0]       Tx_Data,
   output logic             Tx_RdBuff,
   output logic             Tx,
   output logic             Tx_ValidFrame,
   output logic             Tx_AbortedTrans,
   output logic             Tx_Done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START_FLAG,
      S_DATA,
      S_END_FLAG,
      S_ABORT
   } state_t;

   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_BYTES);

   state_t           state, state_nxt;
   logic [2:0]       cnt, cnt_nxt;
   logic [2:0]       ones, ones_nxt;
   logic             eob_pend, eob_pend_nxt;
   logic [LEN_W-1:0] rem, rem_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic             abort_q;
   logic [2:0]       pipe;
   logic             bit_int;
   logic             accept;
   logic             abort_edge;
   logic             stuff;
   logic             byte_end;

   assign accept     = (state == S_IDLE) && Tx_Enable && (Tx_Len != '0) && (Tx_Len <= MAX_L);
   assign abort_edge = Tx_AbortFrame && !abort_q && Tx_ValidFrame;
   assign stuff      = (state == S_DATA) && (ones == 3'd5);
   // A byte is finished once its 8th bit is out and no stuffed 0 is owed;
   // if the 8th bit completes a run of five 1s, eob_pend defers the end of
   // byte to the stuffing cycle.
   assign byte_end   = (state == S_DATA) &&
                       (stuff ? eob_pend
                              : ((cnt == 3'd0) && !(shreg[0] && (ones == 3'd4))));

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      ones_nxt     = ones;
      eob_pend_nxt = eob_pend;
      rem_nxt      = rem;
      shreg_nxt    = shreg;
      bit_int      = 1'b1;
      Tx_RdBuff    = 1'b0;

      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_START_FLAG;
               cnt_nxt   = 3'd7;
               rem_nxt   = Tx_Len;
            end
         end
         S_START_FLAG: begin
            bit_int = (cnt != 3'd7) && (cnt != 3'd0);
            if (cnt == 3'd0) begin
               Tx_RdBuff    = 1'b1;
               state_nxt    = S_DATA;
               cnt_nxt      = 3'd7;
               ones_nxt     = 3'd0;
               eob_pend_nxt = 1'b0;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         S_DATA: begin
            if (stuff) begin
               bit_int  = 1'b0;
               ones_nxt = 3'd0;
            end else begin
               bit_int   = shreg[0];
               ones_nxt  = shreg[0] ? ones + 3'd1 : 3'd0;
               shreg_nxt = {1'b0, shreg[7:1]};
               cnt_nxt   = cnt - 3'd1;
               if ((cnt == 3'd0) && !byte_end)
                  eob_pend_nxt = 1'b1;
            end
            if (byte_end) begin
               eob_pend_nxt = 1'b0;
               if (rem != '0) begin
                  Tx_RdBuff = 1'b1;
               end else begin
                  state_nxt = S_END_FLAG;
                  cnt_nxt   = 3'd7;
               end
            end
         end
         S_END_FLAG: begin
            bit_int = (cnt != 3'd7) && (cnt != 3'd0);
            if (cnt == 3'd0) state_nxt = S_IDLE;
            else             cnt_nxt   = cnt - 3'd1;
         end
         S_ABORT: begin
            bit_int = (cnt != 3'd7);
            if (cnt == 3'd0) state_nxt = S_IDLE;
            else             cnt_nxt   = cnt - 3'd1;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (Tx_RdBuff) begin
         shreg_nxt = Tx_Data;
         rem_nxt   = rem - LEN_W'(1);
      end

      if (abort_edge) begin
         state_nxt = S_ABORT;
         cnt_nxt   = 3'd7;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state           <= S_IDLE;
         cnt             <= 3'd0;
         ones            <= 3'd0;
         eob_pend        <= 1'b0;
         rem             <= '0;
         shreg           <= 8'h00;
         abort_q         <= 1'b0;
         pipe            <= 3'b111;
         Tx_ValidFrame   <= 1'b0;
         Tx_AbortedTrans <= 1'b0;
         Tx_Done         <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         ones          <= ones_nxt;
         eob_pend      <= eob_pend_nxt;
         rem           <= rem_nxt;
         shreg         <= shreg_nxt;
         abort_q       <= Tx_AbortFrame;
         pipe          <= {pipe[1:0], bit_int};
         Tx_ValidFrame <= (state_nxt == S_START_FLAG) || (state_nxt == S_DATA);
         Tx_Done       <= (state == S_END_FLAG) && (cnt == 3'd0);
         if (abort_edge)  Tx_AbortedTrans <= 1'b1;
         else if (accept) Tx_AbortedTrans <= 1'b0;
      end
   end

   assign Tx = pipe[2];

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// tb_hdlc_tx_sequencer
// Directed bench for hdlc_tx_sequencer. Each frame is captured cycle by
// cycle relative to the enable cycle t (bit k of a mask = value at t+k) and
// compared against hand-computed bit patterns.

module tb_hdlc_tx_sequencer;

   logic       Clk = 1'b0;
   logic       Rst = 1'b0;
   logic       Tx_Enable = 1'b0;
   logic [7:0] Tx_Len = 8'd0;
   logic       Tx_AbortFrame = 1'b0;
   logic [7:0] Tx_Data = 8'h00;
   logic       Tx_RdBuff;
   logic       Tx;
   logic       Tx_ValidFrame;
   logic       Tx_AbortedTrans;
   logic       Tx_Done;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]  dbuf [0:3];
   logic [63:0] tx_m, rd_m, done_m, vf_m, ab_m;

   hdlc_tx_sequencer dut (
      .Clk             (Clk),
      .Rst             (Rst),
      .Tx_Enable       (Tx_Enable),
      .Tx_Len          (Tx_Len),
      .Tx_AbortFrame   (Tx_AbortFrame),
      .Tx_Data         (Tx_Data),
      .Tx_RdBuff       (Tx_RdBuff),
      .Tx              (Tx),
      .Tx_ValidFrame   (Tx_ValidFrame),
      .Tx_AbortedTrans (Tx_AbortedTrans),
      .Tx_Done         (Tx_Done)
   );

   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Tx bits from t+from for n cycles, earliest bit in the MSB position.
   function automatic logic [63:0] win(input int from, input int n);
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++) r[n-1-i] = tx_m[from+i];
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge Clk);
   endtask

   // Start a request at cycle t and record ncyc cycles of outputs.
   // en_k / abort_k inject an extra enable or an abort rise at t+k (-1: none).
   task automatic run_frame(input logic [7:0] len, input int ncyc,
                            input int en_k, input int abort_k);
      int idx = 0;
      tx_m = '0; rd_m = '0; done_m = '0; vf_m = '0; ab_m = '0;
      Tx_Data = dbuf[0];
      @(posedge Clk); #1;
      Tx_Enable = 1'b1;
      Tx_Len    = len;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge Clk);
         tx_m[k]   = Tx;
         rd_m[k]   = Tx_RdBuff;
         done_m[k] = Tx_Done;
         vf_m[k]   = Tx_ValidFrame;
         ab_m[k]   = Tx_AbortedTrans;
         @(posedge Clk); #1;
         if (rd_m[k]) begin
            idx++;
            Tx_Data = dbuf[idx[1:0]];
         end
         Tx_Enable = (k + 1 == en_k);
         if (k + 1 == abort_k) Tx_AbortFrame = 1'b1;
      end
      Tx_Enable = 1'b0;
   endtask

   initial begin
      logic [4:0] outs;

      idle(3);
      @(negedge Clk) Rst = 1'b1;
      idle(2);
      @(negedge Clk);
      check_val("reset_outputs",
                {59'd0, Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done, Tx_RdBuff},
                64'b10000);

      // single zero byte
      dbuf[0] = 8'h00;
      run_frame(8'd1, 40, -1, -1);
      check_val("zero_tx",    win(4, 24), 64'b01111110_00000000_01111110);
      check_val("zero_rd",    rd_m,   64'h100);
      check_val("zero_done",  done_m, 64'h2000000);
      check_val("zero_valid", vf_m,   64'h1FFFE);
      check_val("zero_abt",   ab_m,   64'h0);
      check_val("zero_idle",  win(28, 8), 64'hFF);
      idle(4);

      // 0xFF: stuffed 0 after five 1s, none inside flags
      dbuf[0] = 8'hFF;
      run_frame(8'd1, 40, -1, -1);
      check_val("ff_tx",    win(4, 25), 64'b01111110_11111_0_111_01111110);
      check_val("ff_rd",    rd_m,   64'h100);
      check_val("ff_done",  done_m, 64'h4000000);
      check_val("ff_valid", vf_m,   64'h3FFFE);
      idle(4);

      // three bytes, stuffing due right after the 8th bit of 0xF8
      dbuf[0] = 8'h55; dbuf[1] = 8'hF8; dbuf[2] = 8'h01;
      run_frame(8'd3, 52, -1, -1);
      check_val("multi_tx",    win(4, 41),
                64'b01111110_10101010_00011111_0_10000000_01111110);
      check_val("multi_rd",    rd_m,   64'h2010100);
      check_val("multi_done",  done_m, 64'h400_0000_0000);
      check_val("multi_valid", vf_m,   64'h3_FFFF_FFFE);
      idle(4);

      // abort edge at t+20, mid data
      dbuf[0] = 8'h55; dbuf[1] = 8'h55; dbuf[2] = 8'h55;
      run_frame(8'd3, 48, -1, 20);
      check_val("abort_tx",    win(4, 32),
                64'b01111110_10101010_1010_0_1111111_1111);
      check_val("abort_rd",    rd_m,   64'h10100);
      check_val("abort_done",  done_m, 64'h0);
      check_val("abort_valid", vf_m,   64'h1FFFFE);
      check_val("abort_sticky", ab_m,  64'h0000_FFFF_FFE0_0000);
      Tx_AbortFrame = 1'b0;
      idle(4);

      // enable during DATA and abort edge in END_FLAG are ignored;
      // the accepted enable clears the sticky abort flag
      dbuf[0] = 8'h00;
      run_frame(8'd1, 36, 12, 20);
      check_val("ign_tx",   win(4, 24), 64'b01111110_00000000_01111110);
      check_val("ign_rd",   rd_m,   64'h100);
      check_val("ign_done", done_m, 64'h2000000);
      check_val("ign_abt",  ab_m,   64'h1);
      Tx_AbortFrame = 1'b0;
      idle(4);

      // zero length with an abort edge in IDLE: nothing happens
      run_frame(8'd0, 20, -1, 3);
      check_val("len0_tx",    win(0, 20), 64'hFFFFF);
      check_val("len0_rd",    rd_m, 64'h0);
      check_val("len0_valid", vf_m, 64'h0);
      check_val("len0_abt",   ab_m, 64'h0);
      Tx_AbortFrame = 1'b0;
      idle(2);

      // oversize length is ignored as well
      run_frame(8'd127, 16, -1, -1);
      check_val("len127_valid", vf_m, 64'h0);

      // reset in the middle of DATA
      dbuf[0] = 8'h00; dbuf[1] = 8'h00; dbuf[2] = 8'h00;
      @(posedge Clk); #1;
      Tx_Enable = 1'b1;
      Tx_Len    = 8'd3;
      @(posedge Clk); #1;
      Tx_Enable = 1'b0;
      idle(14);
      #1 Rst = 1'b0;
      #1;
      outs = {Tx, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done, Tx_RdBuff};
      check_val("rst_mid_outs", {59'd0, outs}, 64'b10000);
      @(negedge Clk) Rst = 1'b1;
      tx_m = '0; vf_m = '0;
      for (int k = 0; k < 24; k++) begin
         @(negedge Clk);
         tx_m[k] = Tx;
         vf_m[k] = Tx_ValidFrame;
      end
      check_val("rst_after_tx",    win(0, 24), 64'hFFFFFF);
      check_val("rst_after_valid", vf_m, 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
